// File: rtl/video_pkg.sv
// Shared video constants and types for the video_in / video_out blocks.
// The output FSM state type and default frame geometry live here so both sides agree.
package video_pkg;

    localparam int DEFAULT_WIDTH  = 640;
    localparam int DEFAULT_HEIGHT = 480;

    // video_in side: packed pixel FIFO word layout, first pixel in the top byte
    localparam int VIN_PIX_W         = 8;
    localparam int VIN_PIX_PER_WORD  = 4;
    localparam int VIN_WORD_W        = VIN_PIX_W * VIN_PIX_PER_WORD;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VBLANK = 2'd1,
        ACTIVE = 2'd2,
        HBLANK = 2'd3
    } video_out_state_e;

    // Width of a counter that must hold 0..n-1, never narrower than one bit
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_out_write.sv
// Drains a show-ahead FIFO of packed 4-pixel words into a raster pixel stream
// with line/frame valids; the state and counters run one cycle ahead of the registered outputs.
module video_out_write
    import video_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int HEIGHT  = DEFAULT_HEIGHT,
    parameter int H_BLANK = 160,
    parameter int V_BLANK = 1000
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [VIN_WORD_W-1:0] fifo_dout,
    output logic                  fifo_rd,
    output logic                  line_valid,
    output logic                  frame_valid,
    output logic [VIN_PIX_W-1:0]  pixel_out,
    output logic                  frame_start,
    output logic                  underflow
);

    localparam int BLANK_MAX = (H_BLANK > V_BLANK) ? H_BLANK : V_BLANK;
    localparam int COL_W     = cntWidth(WIDTH);
    localparam int LINE_W    = cntWidth(HEIGHT);
    localparam int BLANK_W   = cntWidth(BLANK_MAX);

    video_out_state_e      state_q, state_d;
    logic [COL_W-1:0]      col_q, col_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [BLANK_W-1:0]    blank_q, blank_d;
    logic [VIN_WORD_W-1:0] word_q, word_d;
    logic [VIN_PIX_W-1:0]  pixel_q, pixel_d;
    logic                  lineValid_q, lineValid_d;
    logic                  frameValid_q, frameValid_d;
    logic                  frameStart_q, frameStart_d;
    logic                  underflow_q, underflow_d;
    logic                  fetch;

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q      <= IDLE;
            col_q        <= '0;
            line_q       <= '0;
            blank_q      <= '0;
            word_q       <= '0;
            pixel_q      <= '0;
            lineValid_q  <= 1'b0;
            frameValid_q <= 1'b0;
            frameStart_q <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_q       <= line_d;
            blank_q      <= blank_d;
            word_q       <= word_d;
            pixel_q      <= pixel_d;
            lineValid_q  <= lineValid_d;
            frameValid_q <= frameValid_d;
            frameStart_q <= frameStart_d;
            underflow_q  <= underflow_d;
        end
    end

    // Raster sequencing: one pass through this block per pixel slot
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        blank_d = blank_q;
        unique case (state_q)
            IDLE: begin
                col_d   = '0;
                line_d  = '0;
                blank_d = '0;
                if (enable) state_d = VBLANK;
            end
            VBLANK: begin
                if (blank_q == BLANK_W'(V_BLANK - 1)) begin
                    blank_d = '0;
                    col_d   = '0;
                    line_d  = '0;
                    state_d = ACTIVE;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            ACTIVE: begin
                if (col_q == COL_W'(WIDTH - 1)) begin
                    col_d   = '0;
                    blank_d = '0;
                    if (line_q == LINE_W'(HEIGHT - 1)) begin
                        line_d  = '0;
                        state_d = enable ? VBLANK : IDLE;
                    end else begin
                        line_d  = line_q + LINE_W'(1);
                        state_d = HBLANK;
                    end
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            HBLANK: begin
                if (blank_q == BLANK_W'(H_BLANK - 1)) begin
                    blank_d = '0;
                    state_d = ACTIVE;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A word is fetched at every 4th column; an empty FIFO substitutes a zero word
    assign fetch   = (state_q == ACTIVE) && (col_q[1:0] == 2'b00);
    assign fifo_rd = fetch && !fifo_empty && !RST;

    always_comb begin
        word_d       = word_q;
        pixel_d      = '0;
        underflow_d  = underflow_q;
        lineValid_d  = (state_q == ACTIVE);
        frameValid_d = (state_q == ACTIVE) || (state_q == HBLANK);
        frameStart_d = (state_q == ACTIVE) && (col_q == '0) && (line_q == '0);
        if (fetch) begin
            if (fifo_empty) begin
                word_d      = '0;
                underflow_d = 1'b1;
            end else begin
                pixel_d = fifo_dout[VIN_WORD_W-1 -: VIN_PIX_W];
                word_d  = {fifo_dout[VIN_WORD_W-VIN_PIX_W-1:0], {VIN_PIX_W{1'b0}}};
            end
        end else if (state_q == ACTIVE) begin
            pixel_d = word_q[VIN_WORD_W-1 -: VIN_PIX_W];
            word_d  = {word_q[VIN_WORD_W-VIN_PIX_W-1:0], {VIN_PIX_W{1'b0}}};
        end
    end

    assign line_valid  = lineValid_q;
    assign frame_valid = frameValid_q;
    assign pixel_out   = pixel_q;
    assign frame_start = frameStart_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_video_out_write.sv
// Directed bench for video_out_write on an 8x2 raster with a behavioural show-ahead FIFO.
// Expected pixel/valid/pop values per cycle are hand-derived from the raster timing.
module tb_video_out_write;

    localparam int W  = 8;
    localparam int H  = 2;
    localparam int HB = 3;
    localparam int VB = 5;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd;
    logic        line_valid;
    logic        frame_valid;
    logic [7:0]  pixel_out;
    logic        frame_start;
    logic        underflow;

    logic [31:0] mem [16];
    logic [3:0]  rdPtr;
    logic [3:0]  wrCnt = 4'd0;
    int          popCount = 0;
    int          rdWhileEmpty = 0;
    int          popBase;
    int          vectors = 0;
    int          miscompares = 0;

    video_out_write #(
        .WIDTH  (W),
        .HEIGHT (H),
        .H_BLANK(HB),
        .V_BLANK(VB)
    ) dut (
        .clk        (clk),
        .RST        (RST),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd    (fifo_rd),
        .line_valid (line_valid),
        .frame_valid(frame_valid),
        .pixel_out  (pixel_out),
        .frame_start(frame_start),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    // Show-ahead FIFO: head word visible whenever not empty, popped on fifo_rd
    assign fifo_empty = (rdPtr == wrCnt);
    assign fifo_dout  = mem[rdPtr];

    always @(posedge clk) begin
        if (RST) rdPtr <= 4'd0;
        else if (fifo_rd) rdPtr <= rdPtr + 4'd1;
        if (fifo_rd) popCount <= popCount + 1;
        if (fifo_rd && fifo_empty) rdWhileEmpty <= rdWhileEmpty + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic lv, input logic fv,
                               input logic [7:0] px, input logic fs, input logic rd);
        checkVal({tag, ".line_valid"},  {31'd0, line_valid},  {31'd0, lv});
        checkVal({tag, ".frame_valid"}, {31'd0, frame_valid}, {31'd0, fv});
        checkVal({tag, ".pixel_out"},   {24'd0, pixel_out},   {24'd0, px});
        checkVal({tag, ".frame_start"}, {31'd0, frame_start}, {31'd0, fs});
        checkVal({tag, ".fifo_rd"},     {31'd0, fifo_rd},     {31'd0, rd});
    endtask

    // quiet cycles with everything low, then the cycle that fetches the first word
    task automatic runVblank(input string tag, input int quiet);
        repeat (quiet) begin
            applyStimulus();
            checkOutput(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
        applyStimulus();
        checkOutput({tag, ".fetch"}, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic runLine(input string tag, input logic [7:0] base, input bit first,
                           input bit zero, input int nPix);
        for (int c = 0; c < nPix; c++) begin
            applyStimulus();
            checkOutput(tag, 1'b1, 1'b1, zero ? 8'h00 : 8'(base + c),
                        first && (c == 0), (c == 3) && !zero);
        end
    endtask

    task automatic runHblank(input string tag, input logic rdExp);
        repeat (HB - 1) begin
            applyStimulus();
            checkOutput(tag, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        applyStimulus();
        checkOutput({tag, ".fetch"}, 1'b0, 1'b1, 8'h00, 1'b0, rdExp);
    endtask

    task automatic runIdle(input string tag, input int n);
        repeat (n) begin
            applyStimulus();
            checkOutput(tag, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed no completion, expected $finish before 100000ns");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[0] = 32'h00010203; mem[1] = 32'h04050607;
        mem[2] = 32'h08090A0B; mem[3] = 32'h0C0D0E0F;
        mem[4] = 32'h10111213; mem[5] = 32'h14151617;
        mem[6] = 32'h18191A1B; mem[7] = 32'h1C1D1E1F;

        // Two back-to-back frames, enable dropped during line 0 of the second
        $display("[TB] back-to-back frames");
        wrCnt  = 4'd8;
        enable = 1'b1;
        RST    = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("A.reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("A.reset.underflow", {31'd0, underflow}, 32'd0);
        RST = 1'b0;
        popBase = popCount;
        runVblank("A.vblank", VB);
        runLine("A.f1l0", 8'h00, 1'b1, 1'b0, W);
        runHblank("A.f1hb", 1'b1);
        runLine("A.f1l1", 8'h08, 1'b0, 1'b0, W);
        runVblank("A.gap", VB - 1);
        enable = 1'b0;
        runLine("A.f2l0", 8'h10, 1'b1, 1'b0, W);
        runHblank("A.f2hb", 1'b1);
        runLine("A.f2l1", 8'h18, 1'b0, 1'b0, W);
        runIdle("A.idle", 6);
        checkVal("A.pops", popCount - popBase, 32'd8);
        checkVal("A.underflow", {31'd0, underflow}, 32'd0);

        // Only two words available: line 1 underflows to black, timing unchanged
        $display("[TB] underflow frame");
        RST    = 1'b1;
        wrCnt  = 4'd2;
        enable = 1'b1;
        applyStimulus();
        checkOutput("B.reset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        RST = 1'b0;
        popBase = popCount;
        runVblank("B.vblank", VB);
        runLine("B.l0", 8'h00, 1'b1, 1'b0, W);
        checkVal("B.l0.underflow", {31'd0, underflow}, 32'd0);
        runHblank("B.hb", 1'b0);
        enable = 1'b0;
        runLine("B.l1", 8'h00, 1'b0, 1'b1, W);
        checkVal("B.l1.underflow", {31'd0, underflow}, 32'd1);
        runIdle("B.idle", 4);
        checkVal("B.sticky", {31'd0, underflow}, 32'd1);
        checkVal("B.pops", popCount - popBase, 32'd2);

        // Reset mid-frame at line 1 column 5, then a clean frame after re-enable
        $display("[TB] mid-frame reset");
        RST    = 1'b1;
        wrCnt  = 4'd4;
        enable = 1'b1;
        applyStimulus();
        checkVal("C.reset.underflow", {31'd0, underflow}, 32'd0);
        RST = 1'b0;
        popBase = popCount;
        runVblank("C.vblank", VB);
        runLine("C.l0", 8'h00, 1'b1, 1'b0, W);
        runHblank("C.hb", 1'b1);
        runLine("C.l1part", 8'h08, 1'b0, 1'b0, 5);
        RST = 1'b1;
        applyStimulus();
        checkOutput("C.midreset", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        checkVal("C.midreset.underflow", {31'd0, underflow}, 32'd0);
        RST = 1'b0;
        runVblank("C.revblank", VB);
        enable = 1'b0;
        runLine("C.rl0", 8'h00, 1'b1, 1'b0, W);
        runHblank("C.rhb", 1'b1);
        runLine("C.rl1", 8'h08, 1'b0, 1'b0, W);
        runIdle("C.idle", 4);
        checkVal("C.pops", popCount - popBase, 32'd8);

        checkVal("rd_while_empty", rdWhileEmpty, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/video_out_write.md
VIDEO_OUT_WRITE -- requirements
Module: video_out_write

Interface
REQ-001 SHALL have parameter WIDTH, default 640, meaning active pixels per line; WIDTH SHALL be a multiple of 4.
REQ-002 SHALL have parameter HEIGHT, default 480, meaning active lines per frame.
REQ-003 SHALL have parameter H_BLANK, default 160, meaning idle cycles between consecutive lines of a frame.
REQ-004 SHALL have parameter V_BLANK, default 1000, meaning idle cycles between frames, each with frame_valid=0.
REQ-005 clk  in  1  sole clock; one pixel slot per cycle.
REQ-006 RST  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  level; permits frame emission.
REQ-008 fifo_empty  in  1  show-ahead FIFO has no word.
REQ-009 fifo_dout  in  32  head word, valid when fifo_empty=0; 4 pixels, [31:24] first, [7:0] last.
REQ-010 fifo_rd  out  1  pop strobe, one cycle per consumed word.
REQ-011 line_valid  out  1  pixel_out carries an active pixel.
REQ-012 frame_valid  out  1  high throughout the HEIGHT active lines.
REQ-013 pixel_out  out  8  pixel value.
REQ-014 frame_start  out  1  one-cycle pulse coincident with pixel (0,0).
REQ-015 underflow  out  1  sticky; FIFO was empty when a word was needed.

Function
REQ-016 States SHALL be IDLE, VBLANK, ACTIVE, HBLANK.
REQ-017 IDLE: all outputs 0; go to VBLANK when enable=1.
REQ-018 VBLANK: exactly V_BLANK cycles with frame_valid=0, line_valid=0; then ACTIVE at line 0.
REQ-019 ACTIVE: exactly WIDTH cycles with line_valid=1, frame_valid=1; column counter 0..WIDTH-1.
REQ-020 After ACTIVE of lines 0..HEIGHT-2: HBLANK for exactly H_BLANK cycles, line_valid=0, frame_valid=1; then ACTIVE of next line.
REQ-021 After ACTIVE of line HEIGHT-1: VBLANK if enable=1, else IDLE; enable deassertion mid-frame SHALL NOT truncate the frame.
REQ-022 All outputs SHALL be registered; pixel_out, line_valid, frame_valid, frame_start change only on clk rising edge.
REQ-023 At column c with c%4==0, word SHALL be taken from fifo_dout and fifo_rd pulsed in the same cycle the word is sampled; columns c%4==0..3 output bytes [31:24],[23:16],[15:8],[7:0] of that word on consecutive cycles.
REQ-024 Word fetch SHALL be issued one cycle before the first pixel of that word appears on pixel_out (one-cycle latency FIFO->pixel_out).
REQ-025 If fifo_empty=1 at a fetch point: no pop, the 4 pixels SHALL be 0x00, underflow set to 1, timing unchanged.
REQ-026 fifo_rd SHALL never be asserted when fifo_empty=1 and SHALL pulse exactly WIDTH*HEIGHT/4 times per frame absent underflow.
REQ-027 pixel_out SHALL be 0x00 whenever line_valid=0.
REQ-028 Line counter SHALL wrap HEIGHT-1 -> 0; column counter WIDTH-1 -> 0.
REQ-029 underflow SHALL clear only on RST.

Reset
REQ-030 RST=1 sampled at an edge SHALL force state IDLE, counters 0, all outputs 0, including mid-frame; no pop during reset.
REQ-031 First frame after reset SHALL be preceded by a full VBLANK.

Structure
REQ-032 State enum and default WIDTH/HEIGHT SHALL live in shared package video_pkg, alongside video_in constants.
REQ-033 Counter widths SHALL be derived with $clog2 of parameters; blank counter sized for max(H_BLANK,V_BLANK).
REQ-034 No sub-module; single module with one FSM, column/line/blank counters, 32-bit word register.

Verification (WIDTH=8, HEIGHT=2, H_BLANK=3, V_BLANK=5)
REQ-035 Reset, enable=1, FIFO preloaded 0x00010203,0x04050607,0x08090A0B,0x0C0D0E0F -> 5 idle cycles, line 0 pixels 00..07, 3 HBLANK cycles with frame_valid=1, line 1 pixels 08..0F, frame_start once.
REQ-036 Same, FIFO holds only 2 words -> line 1 pixels 00 x8, underflow=1, fifo_rd pulses exactly 2, timing identical.
REQ-037 enable dropped during line 0 -> frame completes, then IDLE, no further fifo_rd.
REQ-038 RST asserted at line 1 column 5 -> next cycle all outputs 0, state IDLE; re-enable yields full VBLANK then new frame.
REQ-039 Two frames back-to-back -> exactly 5 cycles frame_valid=0 between them, counters wrap, 8 pops total.
